// File: rtl/bram_dp_arbiter.sv
// bram_dp_arbiter: round-robin dual-grant front end for a true dual-port
// byte-enable block RAM with 1-cycle read latency. Grants up to two requests
// per cycle (port A / port B), blocks same-address write hazards between the
// two ports and steers the RAM read data back to the issuing requester.
module bram_dp_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                         CLK,
    input  logic                         RST,

    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0]              req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NREQ*BE_WIDTH-1:0]     req_be,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_wdata,

    output logic [NREQ-1:0]              rsp_valid,
    output logic [NREQ*DATA_WIDTH-1:0]   rsp_data,

    output logic [DATA_WIDTH-1:0]        DI_A,
    output logic [ADDR_WIDTH-1:0]        ADDR_A,
    output logic                         WE_A,
    output logic                         RE_A,
    output logic [BE_WIDTH-1:0]          BE_A,
    input  logic [DATA_WIDTH-1:0]        DO_A,

    output logic [DATA_WIDTH-1:0]        DI_B,
    output logic [ADDR_WIDTH-1:0]        ADDR_B,
    output logic                         WE_B,
    output logic                         RE_B,
    output logic [BE_WIDTH-1:0]          BE_B,
    input  logic [DATA_WIDTH-1:0]        DO_B
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Response tag: which requester a port access belongs to, and its kind.
    typedef struct packed {
        logic             vld;
        logic             wr;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [BE_WIDTH-1:0]   be_arr    [NREQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NREQ];

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic             ga_vld;
    logic             gb_vld;
    logic [IDX_W-1:0] ga_idx;
    logic [IDX_W-1:0] gb_idx;
    tag_t             tag_a;
    tag_t             tag_b;

    // Split the flat request buses into per-requester fields.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            be_arr[i]    = req_be[i*BE_WIDTH +: BE_WIDTH];
            wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin scan from ptr: first valid takes port A, the next
    // hazard-free valid takes port B. Nothing is granted while in reset.
    always_comb begin
        int unsigned j;
        j      = 0;
        ga_vld = 1'b0;
        gb_vld = 1'b0;
        ga_idx = '0;
        gb_idx = '0;
        if (!RST) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                j = (32'(ptr) + k) % NREQ;
                if (req_valid[j]) begin
                    if (!ga_vld) begin
                        ga_vld = 1'b1;
                        ga_idx = IDX_W'(j);
                    end else if (!gb_vld &&
                                 !((addr_arr[j] == addr_arr[ga_idx]) &&
                                   (req_write[j] || req_write[ga_idx]))) begin
                        gb_vld = 1'b1;
                        gb_idx = IDX_W'(j);
                    end
                end
            end
        end
    end

    // Pointer moves past the last granted index in scan order.
    always_comb begin
        ptr_nxt = ptr;
        if (gb_vld) begin
            ptr_nxt = IDX_W'((32'(gb_idx) + 32'd1) % NREQ);
        end else if (ga_vld) begin
            ptr_nxt = IDX_W'((32'(ga_idx) + 32'd1) % NREQ);
        end
    end

    // Ready is the decoded grant.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = (ga_vld && (ga_idx == IDX_W'(i))) ||
                           (gb_vld && (gb_idx == IDX_W'(i)));
        end
    end

    // Drive the RAM ports from the granted requesters; idle ports are all zero.
    always_comb begin
        DI_A   = '0;
        ADDR_A = '0;
        WE_A   = 1'b0;
        RE_A   = 1'b0;
        BE_A   = '0;
        DI_B   = '0;
        ADDR_B = '0;
        WE_B   = 1'b0;
        RE_B   = 1'b0;
        BE_B   = '0;
        if (ga_vld) begin
            DI_A   = wdata_arr[ga_idx];
            ADDR_A = addr_arr[ga_idx];
            BE_A   = be_arr[ga_idx];
            WE_A   = req_write[ga_idx];
            RE_A   = !req_write[ga_idx];
        end
        if (gb_vld) begin
            DI_B   = wdata_arr[gb_idx];
            ADDR_B = addr_arr[gb_idx];
            BE_B   = be_arr[gb_idx];
            WE_B   = req_write[gb_idx];
            RE_B   = !req_write[gb_idx];
        end
    end

    // Round-robin pointer and response tags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr   <= '0;
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            ptr       <= ptr_nxt;
            tag_a.vld <= ga_vld;
            tag_a.wr  <= req_write[ga_idx];
            tag_a.idx <= ga_idx;
            tag_b.vld <= gb_vld;
            tag_b.wr  <= req_write[gb_idx];
            tag_b.idx <= gb_idx;
        end
    end

    // Steer RAM output to the tagged requester; accesses in flight when
    // reset rises are dropped.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!RST && tag_a.vld && (tag_a.idx == IDX_W'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = tag_a.wr ? '0 : DO_A;
            end
            if (!RST && tag_b.vld && (tag_b.idx == IDX_W'(i))) begin
                rsp_valid[i] = 1'b1;
                rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = tag_b.wr ? '0 : DO_B;
            end
        end
    end

    // A requester is never granted both ports in one cycle.
    a_distinct_grants: assert property (@(posedge CLK) disable iff (RST)
        (ga_vld && gb_vld) |-> (ga_idx != gb_idx));

    // Port B never collides with a port-A write, nor writes over a port-A read.
    a_no_hazard: assert property (@(posedge CLK) disable iff (RST)
        (ga_vld && gb_vld && (ADDR_A == ADDR_B)) |-> (RE_A && RE_B));

    // Read and write are exclusive on each port.
    a_port_excl: assert property (@(posedge CLK)
        !(WE_A && RE_A) && !(WE_B && RE_B));

    // Pointer stays inside the requester range.
    a_ptr_range: assert property (@(posedge CLK) disable iff (RST)
        32'(ptr) < NREQ);

endmodule

// File: tb/tb_bram_dp_arbiter.sv
// tb_bram_dp_arbiter: directed vector table plus randomized traffic for
// bram_dp_arbiter, with a behavioural RAM and a list-based arbitration model.
module tb_bram_dp_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam int NROWS = 23;
    localparam int NRAND = 3000;

    logic                 CLK;
    logic                 RST;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*BW-1:0]   req_be;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*DW-1:0]   rsp_data;
    logic [DW-1:0]        DI_A, DI_B, DO_A, DO_B;
    logic [AW-1:0]        ADDR_A, ADDR_B;
    logic                 WE_A, RE_A, WE_B, RE_B;
    logic [BW-1:0]        BE_A, BE_B;

    // Stimulus state, one entry per requester.
    logic [NREQ-1:0]      t_vld;
    logic [NREQ-1:0]      t_wr;
    logic [AW-1:0]        t_addr [NREQ];
    logic [BW-1:0]        t_be   [NREQ];
    logic [DW-1:0]        t_wd   [NREQ];

    // RAM behaviour and reference model state.
    logic [DW-1:0]        ram   [DEPTH];
    logic [DW-1:0]        mem_m [DEPTH];
    logic                 init_pulse;
    int                   ptr_m;
    logic [NREQ-1:0]      exp_rv;
    logic [NREQ*DW-1:0]   exp_rd;
    logic [NREQ-1:0]      last_rdy;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic           rst;
        logic [2:0]     vld;
        logic [2:0]     wr;
        logic [AW-1:0]  a0, a1, a2;
        logic [BW-1:0]  be0;
        logic [DW-1:0]  wd0;
        logic [2:0]     erdy;
        logic [2:0]     erv;
        logic [DW-1:0]  d0, d1, d2;
    } vec_t;

    vec_t tbl [NROWS];

    bram_dp_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .DI_A(DI_A), .ADDR_A(ADDR_A), .WE_A(WE_A), .RE_A(RE_A), .BE_A(BE_A), .DO_A(DO_A),
        .DI_B(DI_B), .ADDR_B(ADDR_B), .WE_B(WE_B), .RE_B(RE_B), .BE_B(BE_B), .DO_B(DO_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Flatten stimulus onto the DUT buses.
    always_comb begin
        req_valid = t_vld;
        req_write = t_wr;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_be[i*BW +: BW]    = t_be[i];
            req_wdata[i*DW +: DW] = t_wd[i];
        end
    end

    // Dual-port RAM with 1-cycle registered read.
    always @(posedge CLK) begin
        if (init_pulse) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= (k == 3) ? 32'h1122_3344 : '0;
            DO_A <= '0;
            DO_B <= '0;
        end else begin
            if (RE_A) DO_A <= ram[ADDR_A];
            if (RE_B) DO_B <= ram[ADDR_B];
            if (WE_A) ram[ADDR_A] <= merge(ram[ADDR_A], DI_A, BE_A);
            if (WE_B) ram[ADDR_B] <= merge(ram[ADDR_B], DI_B, BE_B);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Grants from the rules: list valid requesters in rotated order, the
    // first goes to A, the first later one without a write hazard goes to B.
    function automatic void model_grant(output int ga, output int gb);
        int order[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < NREQ; k++)
            if (t_vld[(ptr_m + k) % NREQ]) order.push_back((ptr_m + k) % NREQ);
        if (order.size() > 0) ga = order[0];
        for (int n = 1; n < order.size(); n++) begin
            int c;
            c = order[n];
            if (gb < 0 && !(t_addr[c] == t_addr[ga] && (t_wr[c] || t_wr[ga]))) gb = c;
        end
    endfunction

    // Compare current outputs with the model, then advance the model one cycle.
    task automatic model_step();
        int ga, gb;
        int gl[2];
        logic [NREQ-1:0]    er;
        logic [NREQ-1:0]    nrv;
        logic [NREQ*DW-1:0] nrd;
        logic [47:0]        pa, pb;
        er = '0; nrv = '0; nrd = '0; pa = '0; pb = '0;
        if (RST) begin
            ga = -1;
            gb = -1;
        end else begin
            model_grant(ga, gb);
        end
        if (ga >= 0) begin
            er[ga] = 1'b1;
            pa = {t_wr[ga], !t_wr[ga], t_addr[ga], t_be[ga], t_wd[ga]};
        end
        if (gb >= 0) begin
            er[gb] = 1'b1;
            pb = {t_wr[gb], !t_wr[gb], t_addr[gb], t_be[gb], t_wd[gb]};
        end
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("rsp_valid", 128'(rsp_valid), RST ? 128'(0) : 128'(exp_rv));
        chk("rsp_data", 128'(rsp_data), RST ? 128'(0) : 128'(exp_rd));
        chk("port_a", 128'({WE_A, RE_A, ADDR_A, BE_A, DI_A}), 128'(pa));
        chk("port_b", 128'({WE_B, RE_B, ADDR_B, BE_B, DI_B}), 128'(pb));
        gl[0] = ga;
        gl[1] = gb;
        foreach (gl[n]) if (gl[n] >= 0) begin
            nrv[gl[n]] = 1'b1;
            if (!t_wr[gl[n]]) nrd[gl[n]*DW +: DW] = mem_m[t_addr[gl[n]]];
        end
        foreach (gl[n]) if (gl[n] >= 0 && t_wr[gl[n]])
            mem_m[t_addr[gl[n]]] = merge(mem_m[t_addr[gl[n]]], t_wd[gl[n]], t_be[gl[n]]);
        if (RST)          ptr_m = 0;
        else if (gb >= 0) ptr_m = (gb + 1) % NREQ;
        else if (ga >= 0) ptr_m = (ga + 1) % NREQ;
        exp_rv   = nrv;
        exp_rd   = nrd;
        last_rdy = er;
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] vld, input logic [2:0] wr,
                                input int a0, input int a1, input int a2,
                                input logic [BW-1:0] be0, input logic [DW-1:0] wd0,
                                input logic [2:0] erdy, input logic [2:0] erv,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.wr = wr;
        v.a0 = AW'(a0); v.a1 = AW'(a1); v.a2 = AW'(a2);
        v.be0 = be0; v.wd0 = wd0; v.erdy = erdy; v.erv = erv;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        return v;
    endfunction

    initial begin
        checks = 0; failures = 0; cyc = 0;
        ptr_m = 0; exp_rv = '0; exp_rd = '0; last_rdy = '0;
        for (int k = 0; k < DEPTH; k++) mem_m[k] = (k == 3) ? 32'h1122_3344 : '0;
        t_vld = '0; t_wr = '0;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0; t_be[i] = '0; t_wd[i] = '0;
        end

        //             rst vld     wr      a0 a1 a2 be0   wd0            rdy     rv      d0             d1             d2
        tbl[0]  = mk(1, 3'b111, 3'b000, 0,  1,  2,  4'hF, 32'h0,         3'b000, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[1]  = mk(1, 3'b111, 3'b000, 0,  1,  2,  4'hF, 32'h0,         3'b000, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[2]  = mk(1, 3'b111, 3'b000, 0,  1,  2,  4'hF, 32'h0,         3'b000, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[3]  = mk(0, 3'b111, 3'b000, 20, 21, 22, 4'hF, 32'h0,         3'b011, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[4]  = mk(0, 3'b101, 3'b001, 5,  21, 22, 4'hF, 32'hDEADBEEF,  3'b101, 3'b011, 32'h0,         32'h0,         32'h0);
        tbl[5]  = mk(0, 3'b001, 3'b001, 5,  21, 22, 4'h1, 32'h000000AA,  3'b001, 3'b101, 32'h0,         32'h0,         32'h0);
        tbl[6]  = mk(0, 3'b001, 3'b000, 5,  21, 22, 4'hF, 32'h0,         3'b001, 3'b001, 32'h0,         32'h0,         32'h0);
        tbl[7]  = mk(0, 3'b100, 3'b000, 5,  21, 9,  4'hF, 32'h0,         3'b100, 3'b001, 32'hDEADBEAA,  32'h0,         32'h0);
        tbl[8]  = mk(0, 3'b111, 3'b001, 7,  7,  9,  4'hF, 32'h12345678,  3'b101, 3'b100, 32'h0,         32'h0,         32'h0);
        tbl[9]  = mk(0, 3'b010, 3'b000, 7,  7,  9,  4'hF, 32'h0,         3'b010, 3'b101, 32'h0,         32'h0,         32'h0);
        tbl[10] = mk(0, 3'b011, 3'b000, 3,  3,  9,  4'hF, 32'h0,         3'b011, 3'b010, 32'h0,         32'h12345678,  32'h0);
        tbl[11] = mk(0, 3'b100, 3'b000, 3,  3,  40, 4'hF, 32'h0,         3'b100, 3'b011, 32'h11223344,  32'h11223344,  32'h0);
        tbl[12] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b011, 3'b100, 32'h0,         32'h0,         32'h0);
        tbl[13] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b101, 3'b011, 32'h0,         32'h0,         32'h0);
        tbl[14] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b110, 3'b101, 32'h0,         32'h0,         32'h0);
        tbl[15] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b011, 3'b110, 32'h0,         32'h0,         32'h0);
        tbl[16] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b101, 3'b011, 32'h0,         32'h0,         32'h0);
        tbl[17] = mk(0, 3'b111, 3'b000, 30, 31, 32, 4'hF, 32'h0,         3'b110, 3'b101, 32'h0,         32'h0,         32'h0);
        tbl[18] = mk(0, 3'b001, 3'b000, 3,  31, 32, 4'hF, 32'h0,         3'b001, 3'b110, 32'h0,         32'h0,         32'h0);
        tbl[19] = mk(1, 3'b000, 3'b000, 3,  31, 32, 4'hF, 32'h0,         3'b000, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[20] = mk(0, 3'b111, 3'b000, 3,  3,  32, 4'hF, 32'h0,         3'b011, 3'b000, 32'h0,         32'h0,         32'h0);
        tbl[21] = mk(0, 3'b100, 3'b000, 3,  3,  32, 4'hF, 32'h0,         3'b100, 3'b011, 32'h11223344,  32'h11223344,  32'h0);
        tbl[22] = mk(0, 3'b000, 3'b000, 3,  3,  32, 4'hF, 32'h0,         3'b000, 3'b100, 32'h0,         32'h0,         32'h0);

        init_pulse = 1'b1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        init_pulse = 1'b0;

        // Directed vectors.
        for (int r = 0; r < NROWS; r++) begin
            RST       = tbl[r].rst;
            t_vld     = tbl[r].vld;
            t_wr      = tbl[r].wr;
            t_addr[0] = tbl[r].a0;
            t_addr[1] = tbl[r].a1;
            t_addr[2] = tbl[r].a2;
            t_be[0]   = tbl[r].be0;
            t_be[1]   = 4'hF;
            t_be[2]   = 4'hF;
            t_wd[0]   = tbl[r].wd0;
            t_wd[1]   = '0;
            t_wd[2]   = '0;
            @(negedge CLK);
            chk($sformatf("tbl%0d_ready", r), 128'(req_ready), 128'(tbl[r].erdy));
            chk($sformatf("tbl%0d_rsp_valid", r), 128'(rsp_valid), 128'(tbl[r].erv));
            chk($sformatf("tbl%0d_rsp_data", r), 128'(rsp_data),
                128'({tbl[r].d2, tbl[r].d1, tbl[r].d0}));
            if (tbl[r].rst) chk($sformatf("tbl%0d_we_re", r), 128'({WE_A, RE_A, WE_B, RE_B}), 128'(0));
            model_step();
            cyc++;
            @(posedge CLK);
            #1;
        end

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < NRAND; n++) begin
            RST = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!t_vld[i] && ($urandom_range(0, 9) < 7)) begin
                    t_vld[i]  = 1'b1;
                    t_wr[i]   = ($urandom_range(0, 2) == 0);
                    t_addr[i] = AW'($urandom_range(0, 7));
                    t_be[i]   = BW'($urandom);
                    t_wd[i]   = $urandom;
                end
            end
            @(negedge CLK);
            model_step();
            cyc++;
            @(posedge CLK);
            #1;
            t_vld = t_vld & ~last_rdy;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_dp_arbiter.md
Name: bram_dp_arbiter

Overview:
- Shares one true dual-port byte-enable block RAM between NREQ requesters, e.g. instruction fetch, data cache and DMA.
- Each cycle it grants up to two requests in round-robin order, one to port A and one to port B.
- It blocks same-address hazards that the RAM reports as X.
- It routes the registered read data back to the requester that issued the access.
- It sits directly in front of the RAM, whose read latency is 1 cycle.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 10, RAM word address width.
- DATA_WIDTH, 32, RAM word width (multiple of 8).
- BE_WIDTH, DATA_WIDTH/8, byte enables per word.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request granted this cycle.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_WIDTH  word address; requester i uses slice i.
- req_be  in  NREQ*BE_WIDTH  byte enables.
- req_wdata  in  NREQ*DATA_WIDTH  write data.
- rsp_valid  out  NREQ  completion pulse (read data or write ack).
- rsp_data  out  NREQ*DATA_WIDTH  read data, slice i.
- DI_A, ADDR_A, WE_A, RE_A, BE_A  out  RAM port A controls, widths as RAM.
- DO_A  in  DATA_WIDTH  RAM port A read data.
- DI_B, ADDR_B, WE_B, RE_B, BE_B  out  RAM port B controls.
- DO_B  in  DATA_WIDTH  RAM port B read data.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Handshake:
  - Transfer occurs when req_valid[i] & req_ready[i].
  - Requester holds all fields stable while valid & !ready.
  - req_ready is combinational from the current req_* inputs and the rr pointer.
- Grant selection, combinational, each cycle:
  - Scan indices ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ).
  - First valid requester found -> port A grant (gA).
  - Next valid requester -> port B grant (gB), unless it conflicts with gA.
  - Conflict: equal addresses and either access is a write. A conflicting candidate is skipped and stays stalled.
  - The scan then continues to later candidates for port B.
  - Two reads to the same address are allowed together.
  - A requester receives at most one grant per cycle.
- Port drive:
  - Granted port: ADDR = addr, DI = wdata, BE = be, WE = write, RE = !write.
  - Idle port: WE = 0, RE = 0, ADDR/DI/BE = 0.
  - A write never asserts RE, so the RAM never produces X on the responding port.
- rr pointer (register):
  - Any grant this cycle -> ptr <= (highest-scanned granted index + 1) mod NREQ, i.e. the index after gB if present, else after gA.
  - No grant -> ptr holds.
- Response pipeline:
  - Registers tagA/tagB (index, valid, is_write) capture the grants.
  - Next cycle: rsp_valid[tag] = 1 for each valid tag.
  - Read: rsp_data[tag] = DO_A or DO_B.
  - Write ack: rsp_data[tag] = 0.
  - Non-responding slices of rsp_data are 0.
  - Latency is exactly 1 cycle after acceptance; no response backpressure.
- Ordering:
  - A requester issues at most one access per cycle, so its responses return in order.
  - Write at cycle t followed by a read of the same address at t+1 returns the new data, via the RAM's write-then-read behaviour.
- Reset (RST = 1):
  - Combinationally, req_ready = 0, WE_A/B = 0, RE_A/B = 0.
  - Next edge: ptr <= 0, tags cleared, rsp_valid = 0 the following cycle.
  - Accesses granted in the cycle before RST rose are dropped: no rsp_valid.
- Boundaries:
  - NREQ = 2: both requesters can be served every cycle.
  - ptr wraps NREQ-1 -> 0.
  - All requesters idle: ports idle, ptr unchanged.

Test Plan:
1. Reset: hold RST 3 cycles with all req_valid = 1 -> req_ready = 0, WE/RE = 0, rsp_valid = 0. After release, the first grant is requester 0 on port A and requester 1 on port B.
2. Write/read:
   - R0 writes 0xDEADBEEF to addr 5, BE = 4'hF -> R0 gets a write ack next cycle with data 0.
   - R0 then writes BE = 4'h1 data 0x000000AA to addr 5, then reads addr 5 -> rsp_data = 0xDEADBEAA, one cycle after acceptance.
3. Hazard: R0 writes addr 7 while R1 reads addr 7 and R2 reads addr 9 -> R0 and R2 granted, R1 stalled. R1 is granted next cycle and reads the written value.
4. Same-address reads: R0 and R1 both read addr 3 (preloaded 0x11223344) -> both granted in one cycle; both rsp_data = 0x11223344.
5. Fairness: all 3 valid for 6 cycles with distinct addresses -> grant pairs are (0,1), (2,0), (1,2), repeating. Each requester gets exactly 4 grants.
6. Reset mid-operation: assert RST the cycle after R0's read is granted -> no rsp_valid[0]; ptr returns to 0.
